// File: rtl/mem_pkg.sv
// Shared defaults and FSM state type for the mem_responder slice.
package mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_WAIT   = 2;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W word storage: synchronous write, registered read port.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic                     rd_clr,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    // rdata holds between reads; rd_clr returns zero for a rejected read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_clr ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: request latch, IDLE/WAIT/RESP FSM, range check.
// Define MEM_ERR_EN to flag out-of-range addresses on err instead of wrapping them.
module mem_responder #(
    parameter int DATA_W = mem_pkg::DEF_DATA_W,
    parameter int ADDR_W = mem_pkg::DEF_ADDR_W,
    parameter int DEPTH  = mem_pkg::DEF_DEPTH,
    parameter int WAIT   = mem_pkg::DEF_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = mem_pkg::CNT_W;
    localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

    mem_pkg::state_t   state;
    mem_pkg::state_t   next_state;
    logic [CNT_W-1:0]  cnt;
    logic              capture;
    logic              enter_resp;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_oor;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        unique case (state)
            mem_pkg::IDLE: begin
                if (req) begin
                    capture    = 1'b1;
                    next_state = (WAIT > 0) ? mem_pkg::WAIT : mem_pkg::RESP;
                end
            end
            mem_pkg::WAIT: begin
                if (cnt == '0) begin
                    next_state = mem_pkg::RESP;
                end
            end
            mem_pkg::RESP: next_state = mem_pkg::IDLE;
            default:       next_state = mem_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= mem_pkg::IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                cnt <= WAIT_LOAD;
            end else if (state == mem_pkg::WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Request latch is pure datapath: it is only consulted after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
        end
    end

    // In IDLE the live inputs feed the array so WAIT=0 can commit on the capture edge.
    assign acc_we     = (state == mem_pkg::IDLE) ? we    : lat_we;
    assign acc_addr   = (state == mem_pkg::IDLE) ? addr  : lat_addr;
    assign acc_wdata  = (state == mem_pkg::IDLE) ? wdata : lat_wdata;
    assign enter_resp = (next_state == mem_pkg::RESP);

`ifdef MEM_ERR_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    assign acc_oor = ({1'b0, acc_addr} >= DEPTH_LIM);
    assign err     = (state == mem_pkg::RESP) && ({1'b0, lat_addr} >= DEPTH_LIM);
`else
    logic unused_addr_hi;

    assign acc_oor        = 1'b0;
    assign err            = 1'b0;
    assign unused_addr_hi = ^acc_addr[ADDR_W-1:IDX_W];
`endif

    assign ack  = (state == mem_pkg::RESP);
    assign busy = (state != mem_pkg::IDLE);

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (enter_resp & acc_we & ~acc_oor),
        .rd_en  (enter_resp & ~acc_we),
        .rd_clr (acc_oor),
        .addr   (acc_addr[IDX_W-1:0]),
        .wdata  (acc_wdata),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 has WAIT=2, instance 1 has WAIT=0.
module tb_mem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_v;
    logic [1:0]  we_v;
    logic [15:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    wire  [1:0]  ack_v;
    wire  [1:0]  busy_v;
    wire  [1:0]  err_v;
    wire  [31:0] rdata_v [2];

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mdl_mem [2][DEPTH];
    logic [31:0] mdl_rd  [2];

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH), .WAIT(2)) dut_w2 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .ack(ack_v[0]), .rdata(rdata_v[0]), .busy(busy_v[0]), .err(err_v[0])
    );

    mem_responder #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH), .WAIT(0)) dut_w0 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .ack(ack_v[1]), .rdata(rdata_v[1]), .busy(busy_v[1]), .err(err_v[1])
    );

    // Reference: a word array per instance plus the last value a read returned.
    task automatic model_apply(input int sel, input logic w, input logic [15:0] a,
                               input logic [31:0] d, output logic [31:0] exp_rd,
                               output logic exp_err);
        int idx;
`ifdef MEM_ERR_EN
        idx     = int'(a);
        exp_err = (idx >= DEPTH);
`else
        idx     = int'(a) % DEPTH;
        exp_err = 1'b0;
`endif
        if (exp_err) begin
            if (!w) mdl_rd[sel] = '0;
        end else if (w) begin
            mdl_mem[sel][idx] = d;
        end else begin
            mdl_rd[sel] = mdl_mem[sel][idx];
        end
        exp_rd = mdl_rd[sel];
    endtask

    function automatic int exp_lat(input int sel);
        return (sel == 0) ? 2 : 0;
    endfunction

    // One transaction; after capture the inputs are scrambled and req dropped.
    task automatic run_txn(input int sel, input logic w, input logic [15:0] a,
                           input logic [31:0] d, output int lat, output logic busy_n1,
                           output logic ack_after, output logic [31:0] rd, output logic e);
        lat       = -1;
        busy_n1   = 1'b0;
        ack_after = 1'b1;
        rd        = '0;
        e         = 1'b0;
        @(negedge clk);
        req_v[sel]   = 1'b1;
        we_v[sel]    = w;
        addr_v[sel]  = a;
        wdata_v[sel] = d;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                busy_n1      = busy_v[sel];
                req_v[sel]   = 1'b0;
                we_v[sel]    = 1'($urandom);
                addr_v[sel]  = 16'($urandom);
                wdata_v[sel] = $urandom;
            end
            if (ack_v[sel]) begin
                lat = k;
                rd  = rdata_v[sel];
                e   = err_v[sel];
                break;
            end
        end
        @(negedge clk);
        ack_after = ack_v[sel];
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        req_v = '0;
        we_v  = '0;
        for (int s = 0; s < 2; s++) begin
            addr_v[s]  = '0;
            wdata_v[s] = '0;
            mdl_rd[s]  = '0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_vec++;
            if ({ack_v[s], busy_v[s], err_v[s]} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_flags[%0d]: ack/busy/err got %b%b%b expected 000", s, ack_v[s], busy_v[s], err_v[s]);
            end
            n_vec++;
            if (rdata_v[s] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_rdata[%0d]: got %h expected 00000000", s, rdata_v[s]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic preload;
        int lat; logic b, aa, e; logic [31:0] rd, xr; logic xe;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < DEPTH; a++) begin
                logic [31:0] d;
                d = $urandom;
                run_txn(s, 1'b1, 16'(a), d, lat, b, aa, rd, e);
                model_apply(s, 1'b1, 16'(a), d, xr, xe);
            end
            n_vec++;
            if (rdata_v[s] !== mdl_rd[s]) begin
                n_bad++;
                $display("FAIL writes_keep_rdata[%0d]: got %h expected %h", s, rdata_v[s], mdl_rd[s]);
            end
        end
    endtask

    task automatic test_latency;
        int lat; logic b, aa, e; logic [31:0] rd, xr; logic xe;
        run_txn(0, 1'b1, 16'h0010, 32'hDEADBEEF, lat, b, aa, rd, e);
        model_apply(0, 1'b1, 16'h0010, 32'hDEADBEEF, xr, xe);
        n_vec++;
        if (lat !== 2) begin n_bad++; $display("FAIL write_latency: got %0d expected 2", lat); end
        n_vec++;
        if (b !== 1'b1) begin n_bad++; $display("FAIL write_busy: got %b expected 1", b); end
        n_vec++;
        if (aa !== 1'b0) begin n_bad++; $display("FAIL write_ack_width: ack after pulse got %b expected 0", aa); end
        n_vec++;
        if (e !== 1'b0) begin n_bad++; $display("FAIL write_err: got %b expected 0", e); end
    endtask

    task automatic test_read_hold;
        int lat; logic b, aa, e; logic [31:0] rd, xr; logic xe;
        run_txn(0, 1'b0, 16'h0010, 32'h0, lat, b, aa, rd, e);
        model_apply(0, 1'b0, 16'h0010, 32'h0, xr, xe);
        n_vec++;
        if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL raw_read: got %h expected deadbeef", rd); end
        n_vec++;
        if (lat !== 2) begin n_bad++; $display("FAIL read_latency: got %0d expected 2", lat); end
        run_txn(0, 1'b1, 16'h0011, $urandom, lat, b, aa, rd, e);
        n_vec++;
        if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL hold_at_write_ack: got %h expected deadbeef", rd); end
        repeat (3) @(negedge clk);
        n_vec++;
        if (rdata_v[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL hold_after_write: got %h expected deadbeef", rdata_v[0]); end
        mdl_mem[0][16'h0011] = 'x;
    endtask

    task automatic test_back_to_back;
        logic [15:0] a [3];
        logic [5:0]  pat;
        logic [31:0] xr;
        logic        xe;
        int          idx;
        for (int i = 0; i < 3; i++) a[i] = 16'($urandom_range(0, DEPTH - 1));
        @(negedge clk);
        req_v[1]  = 1'b1;
        we_v[1]   = 1'b0;
        addr_v[1] = a[0];
        idx = 0;
        pat = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pat[k] = ack_v[1];
            if (ack_v[1] && idx < 3) begin
                model_apply(1, 1'b0, a[idx], 32'h0, xr, xe);
                n_vec++;
                if (rdata_v[1] !== xr) begin
                    n_bad++;
                    $display("FAIL b2b_rdata[%0d]: addr %h got %h expected %h", idx, a[idx], rdata_v[1], xr);
                end
                idx++;
                if (idx < 3) addr_v[1] = a[idx];
                else         req_v[1]  = 1'b0;
            end
        end
        req_v[1] = 1'b0;
        n_vec++;
        if (pat !== 6'b010101) begin n_bad++; $display("FAIL b2b_ack_pattern: got %b expected 010101", pat); end
    endtask

    task automatic test_req_drop;
        logic [15:0] a, bad_a;
        logic [31:0] d, xr;
        logic        xe, b, aa, e;
        logic [31:0] rd;
        int          acks, lat;
        a     = 16'($urandom_range(32, DEPTH - 1));
        bad_a = a ^ 16'h0001;
        d     = $urandom;
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = a; wdata_v[0] = d;
        @(negedge clk);
        req_v[0] = 1'b0; we_v[0] = 1'b0; addr_v[0] = bad_a; wdata_v[0] = ~d;
        model_apply(0, 1'b1, a, d, xr, xe);
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack_v[0]) acks++;
        end
        n_vec++;
        if (acks !== 1) begin n_bad++; $display("FAIL drop_ack_count: got %0d expected 1", acks); end
        run_txn(0, 1'b0, a, 32'h0, lat, b, aa, rd, e);
        model_apply(0, 1'b0, a, 32'h0, xr, xe);
        n_vec++;
        if (rd !== d) begin n_bad++; $display("FAIL drop_orig_addr: got %h expected %h", rd, d); end
        run_txn(0, 1'b0, bad_a, 32'h0, lat, b, aa, rd, e);
        model_apply(0, 1'b0, bad_a, 32'h0, xr, xe);
        n_vec++;
        if (rd !== xr) begin n_bad++; $display("FAIL drop_other_addr: got %h expected %h", rd, xr); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] old, rd, xr;
        logic        b, aa, e, xe;
        int          acks, lat;
        old = mdl_mem[0][5];
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 16'h0005; wdata_v[0] = 32'h12345678;
        @(negedge clk);
        req_v[0] = 1'b0;
        n_vec++;
        if (busy_v[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_v[0]); end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy_v[0], ack_v[0]} !== 2'b00) begin n_bad++; $display("FAIL rstmid_busy_ack: got %b%b expected 00", busy_v[0], ack_v[0]); end
        n_vec++;
        if (rdata_v[0] !== 32'h0) begin n_bad++; $display("FAIL rstmid_rdata: got %h expected 00000000", rdata_v[0]); end
        mdl_rd[0] = '0;
        mdl_rd[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_v[0]) acks++;
        end
        n_vec++;
        if (acks !== 0) begin n_bad++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", acks); end
        run_txn(0, 1'b0, 16'h0005, 32'h0, lat, b, aa, rd, e);
        model_apply(0, 1'b0, 16'h0005, 32'h0, xr, xe);
        n_vec++;
        if (rd !== old) begin n_bad++; $display("FAIL rstmid_old_value: got %h expected %h", rd, old); end
    endtask

    task automatic test_range;
        logic [31:0] d, rd, xr;
        logic        b, aa, e, xe;
        int          lat;
        d = $urandom;
        run_txn(0, 1'b1, 16'h0100, d, lat, b, aa, rd, e);
        model_apply(0, 1'b1, 16'h0100, d, xr, xe);
        n_vec++;
        if ({lat == 2, e, rd} !== {1'b1, xe, xr}) begin
            n_bad++;
            $display("FAIL range_write: lat %0d err %b rdata %h expected lat 2 err %b rdata %h", lat, e, rd, xe, xr);
        end
        run_txn(0, 1'b0, 16'h0100, 32'h0, lat, b, aa, rd, e);
        model_apply(0, 1'b0, 16'h0100, 32'h0, xr, xe);
        n_vec++;
        if ({e, rd} !== {xe, xr}) begin n_bad++; $display("FAIL range_read: err %b rdata %h expected err %b rdata %h", e, rd, xe, xr); end
        run_txn(0, 1'b0, 16'h0000, 32'h0, lat, b, aa, rd, e);
        model_apply(0, 1'b0, 16'h0000, 32'h0, xr, xe);
        n_vec++;
        if ({e, rd} !== {xe, xr}) begin n_bad++; $display("FAIL range_alias0: err %b rdata %h expected err %b rdata %h", e, rd, xe, xr); end
    endtask

    task automatic test_random;
        int          sel, lat;
        logic        w, b, aa, e, xe;
        logic [15:0] a;
        logic [31:0] d, rd, xr;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 1));
            w   = 1'($urandom);
            a   = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
            if (a == 16'h0011 || (a % DEPTH) == 17) a = 16'h0012;
            d   = $urandom;
            run_txn(sel, w, a, d, lat, b, aa, rd, e);
            model_apply(sel, w, a, d, xr, xe);
            n_vec++;
            if ({lat == exp_lat(sel), b, aa, e, rd} !== {1'b1, 1'b1, 1'b0, xe, xr}) begin
                n_bad++;
                $display("FAIL random[%0d] inst %0d we %b addr %h: lat %0d busy %b ack_after %b err %b rdata %h expected lat %0d busy 1 ack_after 0 err %b rdata %h",
                         i, sel, w, a, lat, b, aa, e, rd, exp_lat(sel), xe, xr);
            end
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_latency();
        test_read_hold();
        test_back_to_back();
        test_req_drop();
        test_random();
        test_reset_mid();
        test_range();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DATA_W, default 32, memory word width.
REQ-002 Parameter: ADDR_W, default 16, address width from the CPU address register.
REQ-003 Parameter: DEPTH, default 256, number of words stored.
REQ-004 Parameter: WAIT, default 2, wait cycles per access (0..15).
REQ-005 Port: clk  input  1  single clock, rising edge.
REQ-006 Port: rst  input  1  reset, asynchronous, active-high.
REQ-007 Port: req  input  1  access request from the CPU.
REQ-008 Port: we  input  1  1 = write, 0 = read; qualified by req.
REQ-009 Port: addr  input  ADDR_W  word address.
REQ-010 Port: wdata  input  DATA_W  write data from the CPU buffer register.
REQ-011 Port: ack  output  1  one-cycle completion pulse.
REQ-012 Port: rdata  output  DATA_W  read data, registered.
REQ-013 Port: busy  output  1  high while a transaction is in flight.
REQ-014 Port: err  output  1  error flag accompanying ack; exists only with MEM_ERR_EN.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 IDLE: req=1 sampled at edge N -> latch we/addr/wdata; go to WAIT if WAIT>0, else to RESP.
REQ-017 WAIT: the wait counter SHALL load WAIT-1 on entry and decrement each edge; at 0 it SHALL go to RESP.
REQ-018 RESP: ack=1 for exactly one cycle, then IDLE unconditionally.
REQ-019 Latency: ack SHALL be high in the cycle following edge N+WAIT, so WAIT=0 gives ack in the cycle after the capture edge.
REQ-020 A write SHALL commit to the array on the edge entering RESP; a read SHALL update rdata on that same edge.
REQ-021 rdata SHALL hold its value until the next read completes; writes SHALL NOT alter rdata.
REQ-022 After capture, req/addr/wdata changes SHALL be ignored; a req drop mid-WAIT SHALL NOT abort the transaction.
REQ-023 req is not sampled in WAIT or RESP; req still high in the first IDLE cycle after ack SHALL start a new transaction.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 Read-after-write to the same address in back-to-back transactions SHALL return the new data.

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, counter 0, ack 0, busy 0, rdata 0, err 0.
REQ-027 Array contents SHALL NOT be reset.
REQ-028 Reset mid-transaction SHALL drop the pending access with no array write and no ack.
REQ-029 After rst deasserts, the first capture SHALL occur at the first edge with req=1.

Configuration
REQ-030 Macro MEM_ERR_EN defined: addr >= DEPTH sets err=1 with ack, suppresses the write, and forces rdata to 0 for reads; err=0 for in-range accesses.
REQ-031 Macro MEM_ERR_EN undefined: the address SHALL wrap to its low $clog2(DEPTH) bits, and err SHALL be tied 0.

Structure
REQ-032 Package mem_pkg SHALL hold DATA_W/ADDR_W/DEPTH defaults and the state enum (IDLE, WAIT, RESP).
REQ-033 Sub-module mem_array SHALL hold the storage: synchronous write, registered read, DEPTH x DATA_W, no reset.
REQ-034 mem_responder SHALL contain only the FSM, counter, request latch and range check.

Verification
REQ-035 WAIT=2: write addr 0x0010 data 0xDEADBEEF, req at edge 0 -> busy from edge 0, ack after edge 2, one cycle wide.
REQ-036 Read 0x0010 directly after REQ-035 -> rdata=0xDEADBEEF with ack; rdata holds through a following write to 0x0011.
REQ-037 WAIT=0: three back-to-back reads with req held high -> ack every second cycle, each read returning the correct data.
REQ-038 Drop req and change addr during WAIT -> the original transaction completes with the original address; no second ack.
REQ-039 rst pulse during WAIT of a write of 0x12345678 to 0x0005 -> no ack, busy=0 immediately, a later read of 0x0005 returns the old value.
REQ-040 Access to addr 0x0100 with DEPTH=256: with MEM_ERR_EN, err=1 with ack, rdata=0, no write; without it, the access aliases to 0x0000.
